// File: rtl/wait_event_pkg.sv
// wait_event_pkg: shared types and string-parsing helpers for the wait engine.
package wait_event_pkg;

  typedef enum logic [1:0] {WTR, WTF, WTE, WTV} wait_cmd_e;
  typedef enum logic [1:0] {NONE, EVENT, TIMEOUT, ERROR} wait_status_e;
  typedef enum logic [1:0] {IDLE, ARMED, DONE} wait_state_e;

  // Result of parsing a numeric string argument.
  typedef struct packed {
    logic        ok;
    logic [63:0] val;
  } num_t;

  // Time unit name to picoseconds; 0 flags an unknown unit.
  function automatic longint unit_to_ps(input string unit);
    longint ps;
    ps = 0;
    if (unit == "ps")      ps = 64'sd1;
    else if (unit == "ns") ps = 64'sd1000;
    else if (unit == "us") ps = 64'sd1000000;
    else if (unit == "ms") ps = 64'sd1000000000;
    return ps;
  endfunction

  // Parse a decimal or hex string; an empty string or a stray character is not ok.
  function automatic num_t parse_num(input string s, input logic is_hex);
    num_t        r;
    logic [7:0]  c;
    logic [63:0] d;
    r.ok  = (s.len() != 0);
    r.val = '0;
    for (int i = 0; i < s.len(); i++) begin
      c = s.getc(i);
      if (c >= 8'h30 && c <= 8'h39) begin
        d = 64'(c - 8'h30);
      end else if (is_hex && c >= 8'h41 && c <= 8'h46) begin
        d = 64'(c - 8'h37);
      end else if (is_hex && c >= 8'h61 && c <= 8'h66) begin
        d = 64'(c - 8'h57);
      end else begin
        d    = '0;
        r.ok = 1'b0;
      end
      r.val = is_hex ? {r.val[59:0], d[3:0]} : (r.val * 64'd10 + d);
    end
    return r;
  endfunction

endpackage

// File: rtl/wait_timeout_cnt.sv
// wait_timeout_cnt: counts enabled cycles and flags the cycle on which the
// count reaches i_max_cnt. i_max_cnt == 0 means "no timeout".
module wait_timeout_cnt #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  input  logic                 i_clear,
  input  logic [CNT_WIDTH-1:0] i_max_cnt,
  output logic                 o_expired
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;

  assign w_cnt_next = r_cnt + CNT_WIDTH'(1);

  // Cycle counter, cleared whenever the engine is not waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= w_cnt_next;
    end
  end

  // Expire on the cycle whose increment makes the count equal the limit.
  assign o_expired = i_enable && (i_max_cnt != '0) && (w_cnt_next == i_max_cnt);

endmodule

// File: rtl/wait_event_ext.sv
// wait_event_ext: multi-signal wait engine (rising, falling, either edge,
// value match) with scaled timeout and a status code.
// Optional feature macro: WAIT_EVENT_NTH_EN (i_args[5] = occurrence count N).
module wait_event_ext
  import wait_event_pkg::*;
#(
  parameter int     ARGS_NB    = 6,
  parameter int     WAIT_SIZE  = 5,
  parameter int     WAIT_WIDTH = 8,
  parameter longint CLK_PERIOD = 1000,
  parameter int     CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  string                 i_wait_alias [WAIT_SIZE],
  input  logic                  i_sel_wait,
  input  logic                  i_args_valid,
  input  string                 i_args [ARGS_NB],
  input  logic [WAIT_WIDTH-1:0] i_wait [WAIT_SIZE],
  output logic                  o_wait_done,
  output logic [1:0]            o_wait_status,
  output logic                  o_busy
);

  localparam int IDX_W = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1;
  localparam int BIT_W = (WAIT_WIDTH > 1) ? $clog2(WAIT_WIDTH) : 1;
  localparam logic [63:0] ALL_ONES = '1;
  localparam logic [63:0] CNT_MAX  = (CNT_WIDTH >= 64) ? ALL_ONES :
                                     ((64'd1 << CNT_WIDTH) - 64'd1);
  localparam logic [63:0] CLK_PS   = 64'(CLK_PERIOD);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_ARMED = 2'(ARMED);
  localparam logic [1:0] S_DONE  = 2'(DONE);

  // Registers
  logic [1:0]            r_state;
  wait_cmd_e             r_mode;
  logic [IDX_W-1:0]      r_idx;
  logic [BIT_W-1:0]      r_bit;
  logic [WAIT_WIDTH-1:0] r_value;
  logic [WAIT_WIDTH-1:0] r_prev;
  logic [CNT_WIDTH-1:0]  r_max_cnt;
  logic [1:0]            r_pend;
  logic [1:0]            r_status;
  logic                  r_done;

  // Decode wires
  wait_cmd_e             w_cmd;
  logic                  w_cmd_ok;
  logic [IDX_W-1:0]      w_alias_idx;
  logic                  w_alias_ok;
  num_t                  w_bit_num;
  num_t                  w_val_num;
  num_t                  w_tmo_num;
  logic                  w_arg2_ok;
  logic [BIT_W-1:0]      w_bit;
  logic [WAIT_WIDTH-1:0] w_value;
  logic [63:0]           w_unit_ps;
  logic                  w_tmo_ok;
  logic [63:0]           w_prod;
  logic [63:0]           w_quot;
  logic [CNT_WIDTH-1:0]  w_max_cnt;
  logic                  w_nth_ok;
  logic                  w_dec_err;

  // Armed-state wires
  logic [WAIT_WIDTH-1:0] w_cur;
  logic                  w_hit;
  logic                  w_event;
  logic                  w_expired;

  // Command and alias lookup; the lowest matching alias index wins.
  always_comb begin
    w_cmd    = WTR;
    w_cmd_ok = 1'b1;
    if (i_args[0] == "WTR")      w_cmd = WTR;
    else if (i_args[0] == "WTF") w_cmd = WTF;
    else if (i_args[0] == "WTE") w_cmd = WTE;
    else if (i_args[0] == "WTV") w_cmd = WTV;
    else                         w_cmd_ok = 1'b0;
    w_alias_ok  = 1'b0;
    w_alias_idx = '0;
    for (int k = WAIT_SIZE - 1; k >= 0; k--) begin
      if (i_wait_alias[k] == i_args[1]) begin
        w_alias_ok  = 1'b1;
        w_alias_idx = IDX_W'(k);
      end
    end
  end

  // Bit index / match value and timeout scaling (64-bit, floored, min 1, saturated).
  always_comb begin
    w_bit_num = parse_num(i_args[2], 1'b0);
    w_val_num = parse_num(i_args[2], 1'b1);
    w_arg2_ok = 1'b1;
    w_bit     = '0;
    w_value   = '0;
    if (w_cmd == WTV) begin
      w_arg2_ok = w_val_num.ok && ((w_val_num.val >> WAIT_WIDTH) == 64'd0);
      w_value   = w_val_num.val[WAIT_WIDTH-1:0];
    end else if (i_args[2] != "") begin
      w_arg2_ok = w_bit_num.ok && (w_bit_num.val < 64'(WAIT_WIDTH));
      w_bit     = w_bit_num.val[BIT_W-1:0];
    end

    w_tmo_num = parse_num(i_args[3], 1'b0);
    w_unit_ps = 64'(unit_to_ps(i_args[4]));
    w_tmo_ok  = ((i_args[3] == "") || w_tmo_num.ok) &&
                ((i_args[4] == "") || (w_unit_ps != 64'd0));
    w_prod    = '0;
    w_quot    = '0;
    w_max_cnt = '0;
    if (w_tmo_ok && (i_args[3] != "") && (i_args[4] != "") && (w_tmo_num.val != 64'd0)) begin
      if (w_tmo_num.val > (ALL_ONES / w_unit_ps)) w_prod = ALL_ONES;
      else                                        w_prod = w_tmo_num.val * w_unit_ps;
      w_quot = w_prod / CLK_PS;
      if (w_quot == 64'd0)  w_quot = 64'd1;
      if (w_quot > CNT_MAX) w_quot = CNT_MAX;
      w_max_cnt = w_quot[CNT_WIDTH-1:0];
    end
  end

`ifdef WAIT_EVENT_NTH_EN
  num_t                 w_nth_num;
  logic [63:0]          w_nth_sat;
  logic [CNT_WIDTH-1:0] w_occ_tgt;
  logic [CNT_WIDTH-1:0] r_occ_tgt;
  logic [CNT_WIDTH-1:0] r_occ_cnt;

  // Occurrence target: empty or zero means the first occurrence.
  always_comb begin
    w_nth_num = parse_num(i_args[5], 1'b0);
    w_nth_ok  = (i_args[5] == "") || w_nth_num.ok;
    w_nth_sat = 64'd1;
    if ((i_args[5] != "") && (w_nth_num.val != 64'd0)) begin
      w_nth_sat = (w_nth_num.val > CNT_MAX) ? CNT_MAX : w_nth_num.val;
    end
    w_occ_tgt = w_nth_sat[CNT_WIDTH-1:0];
  end

  // Occurrence bookkeeping: restart on arm, count every qualifying cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ_tgt <= '0;
      r_occ_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_occ_tgt <= w_occ_tgt;
      r_occ_cnt <= '0;
    end else if ((r_state == S_ARMED) && w_hit) begin
      r_occ_cnt <= r_occ_cnt + CNT_WIDTH'(1);
    end
  end

  assign w_event = w_hit && ((r_occ_cnt + CNT_WIDTH'(1)) == r_occ_tgt);
`else
  assign w_nth_ok = 1'b1;
  assign w_event  = w_hit;
`endif

  assign w_dec_err = !(w_cmd_ok && w_alias_ok && w_arg2_ok && w_tmo_ok && w_nth_ok);

  // Event detection on the selected watch word against last cycle's sample.
  always_comb begin
    w_cur = i_wait[r_idx];
    case (r_mode)
      WTR:     w_hit = !r_prev[r_bit] &&  w_cur[r_bit];
      WTF:     w_hit =  r_prev[r_bit] && !w_cur[r_bit];
      WTE:     w_hit =  r_prev[r_bit] ^   w_cur[r_bit];
      WTV:     w_hit = (w_cur == r_value);
      default: w_hit = 1'b0;
    endcase
  end

  wait_timeout_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_enable  (r_state == S_ARMED),
    .i_clear   (r_state != S_ARMED),
    .i_max_cnt (r_max_cnt),
    .o_expired (w_expired)
  );

  // Main FSM: IDLE -> ARMED/DONE on a command, DONE emits the registered pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mode    <= WTR;
      r_idx     <= '0;
      r_bit     <= '0;
      r_value   <= '0;
      r_prev    <= '0;
      r_max_cnt <= '0;
      r_pend    <= NONE;
      r_status  <= NONE;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_sel_wait && i_args_valid) begin
            r_status <= NONE;
            if (w_dec_err) begin
              r_pend  <= ERROR;
              r_state <= S_DONE;
            end else begin
              r_mode    <= w_cmd;
              r_idx     <= w_alias_idx;
              r_bit     <= w_bit;
              r_value   <= w_value;
              r_max_cnt <= w_max_cnt;
              r_prev    <= i_wait[w_alias_idx];
              r_state   <= S_ARMED;
            end
          end
        end
        S_ARMED: begin
          r_prev <= w_cur;
          if (!i_sel_wait) begin
            r_state <= S_IDLE;
          end else if (w_event) begin
            r_pend  <= EVENT;
            r_state <= S_DONE;
          end else if (w_expired) begin
            r_pend  <= TIMEOUT;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done   <= 1'b1;
          r_status <= r_pend;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_wait_done   = r_done;
  assign o_wait_status = r_status;
  assign o_busy        = (r_state == S_ARMED);

endmodule

// File: tb/tb_wait_event_ext.sv
// tb_wait_event_ext: directed self-checking bench for wait_event_ext.
// Honours WAIT_EVENT_NTH_EN for the occurrence-count step.
module tb_wait_event_ext;

  logic       clk;
  logic       rst;
  logic       sel_wait;
  logic       args_valid;
  string      alias_tb [5];
  string      args_tb [6];
  logic [7:0] wait_sig [5];
  logic       wait_done;
  logic [1:0] wait_status;
  logic       busy;

  int n_checks;
  int n_errors;

  wait_event_ext #(
    .ARGS_NB    (6),
    .WAIT_SIZE  (5),
    .WAIT_WIDTH (8),
    .CLK_PERIOD (1000),
    .CNT_WIDTH  (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_wait_alias  (alias_tb),
    .i_sel_wait    (sel_wait),
    .i_args_valid  (args_valid),
    .i_args        (args_tb),
    .i_wait        (wait_sig),
    .o_wait_done   (wait_done),
    .o_wait_status (wait_status),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic arm(input string a0, input string a1, input string a2,
                     input string a3, input string a4, input string a5);
    args_tb[0] = a0; args_tb[1] = a1; args_tb[2] = a2;
    args_tb[3] = a3; args_tb[4] = a4; args_tb[5] = a5;
    args_valid = 1'b1;
    tick();
    args_valid = 1'b0;
    $display("arm %s %s %s %s %s %s", a0, a1, a2, a3, a4, a5);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    sel_wait = 1'b1;
    args_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      alias_tb[i] = $sformatf("sig%0d", i);
      wait_sig[i] = 8'h00;
    end
    for (int i = 0; i < 6; i++) args_tb[i] = "";

    // Reset state
    tick(); tick();
    chk("rst_done", {7'd0, wait_done}, 8'h00);
    chk("rst_status", {6'd0, wait_status}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    rst = 1'b0;
    tick();

    // 1: WTR sig0 bit 3, no timeout, rise 10 cycles after arm
    arm("WTR", "sig0", "3", "", "", "");
    chk("t1_busy", {7'd0, busy}, 8'h01);
    repeat (4) tick();
    args_tb[0] = "WTX";
    args_valid = 1'b1;
    tick();
    args_valid = 1'b0;
    chk("t1_ignore_args", {7'd0, busy}, 8'h01);
    repeat (4) tick();
    chk("t1_no_early_done", {7'd0, wait_done}, 8'h00);
    wait_sig[0] = 8'h08;
    tick();
    chk("t1_done_lat1", {7'd0, wait_done}, 8'h00);
    tick();
    chk("t1_done", {7'd0, wait_done}, 8'h01);
    chk("t1_status", {6'd0, wait_status}, 8'h01);
    tick();
    chk("t1_pulse_end", {7'd0, wait_done}, 8'h00);
    chk("t1_status_held", {6'd0, wait_status}, 8'h01);

    // 2: WTF sig1 bit 0, 20 ns timeout, no edge
    wait_sig[1] = 8'h01;
    arm("WTF", "sig1", "0", "20", "ns", "");
    chk("t2_status_clr", {6'd0, wait_status}, 8'h00);
    repeat (19) tick();
    chk("t2_busy_19", {7'd0, busy}, 8'h01);
    tick();
    chk("t2_busy_20", {7'd0, busy}, 8'h00);
    chk("t2_done_lat", {7'd0, wait_done}, 8'h00);
    tick();
    chk("t2_done", {7'd0, wait_done}, 8'h01);
    chk("t2_status", {6'd0, wait_status}, 8'h02);

    // 3: WTV sig2 A5
    arm("WTV", "sig2", "A5", "", "", "");
    tick();
    wait_sig[2] = 8'h5A;
    tick();
    chk("t3_no_match", {7'd0, busy}, 8'h01);
    wait_sig[2] = 8'hA5;
    tick();
    chk("t3_done_lat", {7'd0, wait_done}, 8'h00);
    tick();
    chk("t3_done", {7'd0, wait_done}, 8'h01);
    chk("t3_status", {6'd0, wait_status}, 8'h01);
    arm("WTV", "sig2", "a5", "", "", "");
    tick();
    chk("t3b_done_lat", {7'd0, wait_done}, 8'h00);
    tick();
    chk("t3b_done", {7'd0, wait_done}, 8'h01);
    chk("t3b_status", {6'd0, wait_status}, 8'h01);

    // 4: error commands
    arm("WTX", "sig0", "0", "", "", "");
    chk("t4_cmd_busy", {7'd0, busy}, 8'h00);
    tick();
    chk("t4_cmd_done", {7'd0, wait_done}, 8'h01);
    chk("t4_cmd_status", {6'd0, wait_status}, 8'h03);
    tick();
    chk("t4_cmd_pulse_end", {7'd0, wait_done}, 8'h00);
    arm("WTR", "nope", "0", "", "", "");
    tick();
    chk("t4_alias_done", {7'd0, wait_done}, 8'h01);
    chk("t4_alias_status", {6'd0, wait_status}, 8'h03);
    tick();
    arm("WTR", "sig0", "8", "", "", "");
    tick();
    chk("t4_bit_done", {7'd0, wait_done}, 8'h01);
    chk("t4_bit_status", {6'd0, wait_status}, 8'h03);
    tick();
    arm("WTR", "sig0", "0", "5", "s", "");
    tick();
    chk("t4_unit_done", {7'd0, wait_done}, 8'h01);
    chk("t4_unit_status", {6'd0, wait_status}, 8'h03);
    tick();

    // 5a: edge and timeout on the same cycle, event wins
    wait_sig[3] = 8'h00;
    arm("WTR", "sig3", "0", "5", "ns", "");
    repeat (4) tick();
    chk("t5a_busy", {7'd0, busy}, 8'h01);
    wait_sig[3] = 8'h01;
    tick();
    tick();
    chk("t5a_done", {7'd0, wait_done}, 8'h01);
    chk("t5a_status", {6'd0, wait_status}, 8'h01);

    // 5b: drop i_sel_wait mid-ARMED
    wait_sig[3] = 8'h00;
    arm("WTR", "sig3", "0", "7", "us", "");
    chk("t5b_busy", {7'd0, busy}, 8'h01);
    chk("t5b_status_clr", {6'd0, wait_status}, 8'h00);
    tick(); tick();
    sel_wait = 1'b0;
    tick();
    chk("t5b_abort_busy", {7'd0, busy}, 8'h00);
    chk("t5b_abort_done", {7'd0, wait_done}, 8'h00);
    tick();
    chk("t5b_no_pulse", {7'd0, wait_done}, 8'h00);
    chk("t5b_status", {6'd0, wait_status}, 8'h00);
    sel_wait = 1'b1;

    // 5c: asynchronous reset mid-ARMED
    wait_sig[4] = 8'h00;
    arm("WTR", "sig4", "0", "", "", "");
    chk("t5c_busy", {7'd0, busy}, 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("t5c_rst_busy", {7'd0, busy}, 8'h00);
    chk("t5c_rst_done", {7'd0, wait_done}, 8'h00);
    tick();
    rst = 1'b0;
    wait_sig[4] = 8'h01;
    tick(); tick();
    chk("t5c_after_rst_done", {7'd0, wait_done}, 8'h00);
    chk("t5c_after_rst_busy", {7'd0, busy}, 8'h00);

    // 6: WTE sig4 bit 1 with occurrence count 3
    wait_sig[4] = 8'h00;
    arm("WTE", "sig4", "1", "", "", "3");
    wait_sig[4] = 8'h02;
    tick();
`ifdef WAIT_EVENT_NTH_EN
    wait_sig[4] = 8'h00;
    tick();
    chk("t6_busy_after2", {7'd0, busy}, 8'h01);
    chk("t6_no_done_after2", {7'd0, wait_done}, 8'h00);
    wait_sig[4] = 8'h02;
    tick();
`endif
    chk("t6_busy_off", {7'd0, busy}, 8'h00);
    tick();
    chk("t6_done", {7'd0, wait_done}, 8'h01);
    chk("t6_status", {6'd0, wait_status}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
